// File: rtl/ddr3_we_n_lane_ctrl.sv
// Fabric-side driver for the DDR3 WE_N lane: packs commands into the four serializer slots
// (1T/2T with slot-3 spill) and walks the IOD output delay line to a requested tap.
module ddr3_we_n_lane_ctrl #(
    parameter int T2_MODE    = 0,
    parameter int INIT_HOLD  = 16,
    parameter int INIT_TAP   = 1,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 4
) (
    input  logic       fab_clk,
    input  logic       tx_sync_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we_n,
    input  logic [1:0] cmd_slot,
    output logic [3:0] tx_data_0,
    output logic [3:0] oe_data_0,
    output logic       cmd_collide,
    input  logic       tap_req_valid,
    output logic       tap_req_ready,
    input  logic [7:0] tap_req_target,
    output logic [7:0] tap_cur,
    output logic       tap_done,
    output logic       tap_err,
    output logic       delay_line_move_0,
    output logic       delay_line_direction_0,
    output logic       delay_line_load_0,
    input  logic       delay_line_out_of_range_0
);

    localparam int HOLD_W = (INIT_HOLD > 1) ? $clog2(INIT_HOLD) : 1;
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(INIT_HOLD - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [7:0] INIT_TAP_L = 8'(INIT_TAP);
    localparam logic [7:0] MAX_TAP_L  = 8'(MAX_TAP);
    localparam bit T2 = (T2_MODE != 0);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_IDLE,
        ST_CHECK,
        ST_STEP,
        ST_DONE
    } tap_state_t;

    // ---------------- command packing ----------------
    logic              cmd_accept;
    logic [3:0]        cmd_vec;
    logic              spill_next;
    logic              spill;
    logic [HOLD_W-1:0] hold_cnt;

    assign cmd_accept = cmd_valid && cmd_ready;

    // NOTE: every signal gets its default before any condition, so no path can infer a latch.
    always_comb begin
        cmd_vec    = 4'hF;
        spill_next = 1'b0;
        if (cmd_accept && !cmd_we_n) begin
            cmd_vec[cmd_slot] = 1'b0;
            if (T2) begin
                if (cmd_slot == 2'd3) spill_next = 1'b1;
                else                  cmd_vec[cmd_slot + 2'd1] = 1'b0;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            tx_data_0   <= 4'hF;
            oe_data_0   <= 4'h0;
            cmd_ready   <= 1'b0;
            cmd_collide <= 1'b0;
            spill       <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            // A pending 2T spill owns slot 0 of this cycle regardless of the new command.
            tx_data_0 <= spill ? (cmd_vec & 4'b1110) : cmd_vec;
            spill     <= spill_next;
            if (spill && !cmd_vec[0]) cmd_collide <= 1'b1;
            if (!cmd_ready) begin
                if (hold_cnt == HOLD_LAST) begin
                    cmd_ready <= 1'b1;
                    oe_data_0 <= 4'hF;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- delay-line tap sequencer ----------------
    tap_state_t       tap_state;
    logic [7:0]       tap_target;
    logic [SET_W-1:0] settle_cnt;
    logic             move_seen;

    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            tap_state              <= ST_LOAD;
            tap_cur                <= INIT_TAP_L;
            tap_target             <= 8'd0;
            settle_cnt             <= '0;
            move_seen              <= 1'b0;
            tap_req_ready          <= 1'b0;
            tap_done               <= 1'b0;
            tap_err                <= 1'b0;
            delay_line_move_0      <= 1'b0;
            delay_line_direction_0 <= 1'b0;
            delay_line_load_0      <= 1'b0;
        end else begin
            delay_line_load_0 <= 1'b0;
            delay_line_move_0 <= 1'b0;
            tap_done          <= 1'b0;
            case (tap_state)
                ST_LOAD: begin
                    delay_line_load_0 <= 1'b1;
                    tap_cur           <= INIT_TAP_L;
                    move_seen         <= 1'b0;
                    settle_cnt        <= SETTLE_LAST;
                    tap_state         <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // The IOD flags a step it could not take; roll the tap count back to match.
                    if (move_seen && delay_line_out_of_range_0) begin
                        tap_err   <= 1'b1;
                        tap_cur   <= delay_line_direction_0 ? tap_cur - 8'd1 : tap_cur + 8'd1;
                        tap_state <= ST_DONE;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (!move_seen) begin
                        tap_req_ready <= 1'b1;
                        tap_state     <= ST_IDLE;
                    end else if (tap_cur == tap_target) begin
                        tap_state <= ST_DONE;
                    end else begin
                        tap_state <= ST_STEP;
                    end
                end
                ST_IDLE: begin
                    if (tap_req_valid) begin
                        tap_req_ready <= 1'b0;
                        tap_err       <= 1'b0;
                        tap_target    <= tap_req_target;
                        tap_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (tap_target > MAX_TAP_L) begin
                        tap_err   <= 1'b1;
                        tap_state <= ST_DONE;
                    end else if (tap_target == tap_cur) begin
                        tap_state <= ST_DONE;
                    end else begin
                        tap_state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    delay_line_move_0 <= 1'b1;
                    move_seen         <= 1'b1;
                    if (tap_target > tap_cur) begin
                        delay_line_direction_0 <= 1'b1;
                        tap_cur                <= tap_cur + 8'd1;
                    end else begin
                        delay_line_direction_0 <= 1'b0;
                        tap_cur                <= tap_cur - 8'd1;
                    end
                    settle_cnt <= SETTLE_LAST;
                    tap_state  <= ST_SETTLE;
                end
                ST_DONE: begin
                    tap_done      <= 1'b1;
                    tap_req_ready <= 1'b1;
                    tap_state     <= ST_IDLE;
                end
                default: tap_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_we_n_lane_ctrl.sv
// Bench for ddr3_we_n_lane_ctrl: one 1T and one 2T instance share stimulus; outputs are
// compared against a slot-set model of the lane and a distance-based model of tap moves.
module tb_ddr3_we_n_lane_ctrl;

    localparam int INIT_HOLD  = 16;
    localparam int INIT_TAP   = 1;
    localparam int MAX_TAP    = 127;
    localparam int SETTLE_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_we_n;
    logic [1:0] cmd_slot;
    logic       tap_req_valid;
    logic [7:0] tap_req_target;
    logic       oor;

    logic       a_ready, a_coll, a_tap_ready, a_tap_done, a_tap_err, a_move, a_dir, a_load;
    logic [3:0] a_tx, a_oe;
    logic [7:0] a_tap_cur;
    logic       b_ready, b_coll, b_tap_ready, b_tap_done, b_tap_err, b_move, b_dir, b_load;
    logic [3:0] b_tx, b_oe;
    logic [7:0] b_tap_cur;

    int n_vec = 0;
    int n_err = 0;
    int m_tap;
    bit m_err;
    bit m_coll_a, m_coll_b;

    always #5 clk = ~clk;

    ddr3_we_n_lane_ctrl #(.T2_MODE(0), .INIT_HOLD(INIT_HOLD), .INIT_TAP(INIT_TAP),
                          .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE_CYC)) dut_1t (
        .fab_clk(clk), .tx_sync_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(a_ready), .cmd_we_n(cmd_we_n), .cmd_slot(cmd_slot),
        .tx_data_0(a_tx), .oe_data_0(a_oe), .cmd_collide(a_coll),
        .tap_req_valid(tap_req_valid), .tap_req_ready(a_tap_ready), .tap_req_target(tap_req_target),
        .tap_cur(a_tap_cur), .tap_done(a_tap_done), .tap_err(a_tap_err),
        .delay_line_move_0(a_move), .delay_line_direction_0(a_dir), .delay_line_load_0(a_load),
        .delay_line_out_of_range_0(oor));

    ddr3_we_n_lane_ctrl #(.T2_MODE(1), .INIT_HOLD(INIT_HOLD), .INIT_TAP(INIT_TAP),
                          .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE_CYC)) dut_2t (
        .fab_clk(clk), .tx_sync_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(b_ready), .cmd_we_n(cmd_we_n), .cmd_slot(cmd_slot),
        .tx_data_0(b_tx), .oe_data_0(b_oe), .cmd_collide(b_coll),
        .tap_req_valid(tap_req_valid), .tap_req_ready(b_tap_ready), .tap_req_target(tap_req_target),
        .tap_cur(b_tap_cur), .tap_done(b_tap_done), .tap_err(b_tap_err),
        .delay_line_move_0(b_move), .delay_line_direction_0(b_dir), .delay_line_load_0(b_load),
        .delay_line_out_of_range_0(oor));

    // Expected lane pattern: a slot is low if the command or a carried-over spill claims it.
    function automatic logic [3:0] lane_model(input bit t2, input bit acc, input bit we_n,
                                              input int slot, input bit spill_in);
        logic [3:0] v;
        v = 4'hF;
        for (int s = 0; s < 4; s++) begin
            if (acc && !we_n && (s == slot || (t2 && s == slot + 1))) v[s] = 1'b0;
            if (spill_in && s == 0) v[s] = 1'b0;
        end
        return v;
    endfunction

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_we_n = 1'b1; cmd_slot = 2'd0;
    endtask

    task automatic check_reset_values(input string name);
        logic [45:0] got, exp;
        got = {a_tx, a_oe, a_ready, a_coll, a_move, a_dir, a_load, a_tap_done, a_tap_err,
               a_tap_ready, a_tap_cur, b_tx, b_oe, b_ready, b_coll, b_tap_cur, b_load, b_move};
        exp = {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 8'(INIT_TAP), 4'hF, 4'h0, 1'b0, 1'b0, 8'(INIT_TAP), 1'b0, 1'b0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: outputs %h, want %h", name, got, exp);
        end
    endtask

    task automatic count_init(input string name);
        int loads;
        loads = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_load === 1'b1) loads++;
            n_vec++;
            if (a_ready !== (k >= INIT_HOLD) || b_ready !== (k >= INIT_HOLD)) begin
                n_err++;
                $display("FAIL %s ready k=%0d: got %b/%b want %b", name, k, a_ready, b_ready, k >= INIT_HOLD);
            end
            n_vec++;
            if (a_oe !== ((k >= INIT_HOLD) ? 4'hF : 4'h0) || a_tx !== 4'hF) begin
                n_err++;
                $display("FAIL %s oe/tx k=%0d: got %h/%h", name, k, a_oe, a_tx);
            end
        end
        n_vec++;
        if (loads != 1) begin
            n_err++;
            $display("FAIL %s load pulses: got %0d want 1", name, loads);
        end
        n_vec++;
        if (a_tap_cur !== 8'(INIT_TAP)) begin
            n_err++;
            $display("FAIL %s tap_cur: got %0d want %0d", name, a_tap_cur, INIT_TAP);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tap_req_valid = 1'b0; tap_req_target = 8'd0; oor = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst = 1'b0;
        count_init("init");
        m_tap = INIT_TAP; m_err = 1'b0; m_coll_a = 1'b0; m_coll_b = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [3:0] ea, input logic [3:0] eb);
        n_vec++;
        if (a_tx !== ea || b_tx !== eb) begin
            n_err++;
            $display("FAIL %s: tx 1T=%b 2T=%b, want %b %b", name, a_tx, b_tx, ea, eb);
        end
    endtask

    task automatic test_t1_directed();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we_n = 1'b0; cmd_slot = 2'd2;
        @(negedge clk);
        expect_tx("slot2_cmd", 4'b1011, 4'b0011);
        drive_idle();
        @(negedge clk);
        expect_tx("slot2_idle", 4'hF, 4'hF);
        cmd_valid = 1'b1; cmd_we_n = 1'b1; cmd_slot = 2'd1;
        @(negedge clk);
        expect_tx("we_n_high_cmd", 4'hF, 4'hF);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_t2_spill_collide();
        cmd_valid = 1'b1; cmd_we_n = 1'b0; cmd_slot = 2'd3;
        @(negedge clk);
        expect_tx("slot3_cmd", 4'b0111, 4'b0111);
        drive_idle();
        @(negedge clk);
        expect_tx("slot3_spill", 4'hF, 4'b1110);
        n_vec++;
        if (b_coll !== 1'b0) begin
            n_err++;
            $display("FAIL spill_no_collide: got %b want 0", b_coll);
        end
        cmd_valid = 1'b1; cmd_we_n = 1'b0; cmd_slot = 2'd3;
        @(negedge clk);
        expect_tx("slot3_again", 4'b0111, 4'b0111);
        cmd_slot = 2'd0;
        @(negedge clk);
        expect_tx("spill_and_slot0", 4'b1110, 4'b1100);
        n_vec++;
        if (b_coll !== 1'b1 || a_coll !== 1'b0) begin
            n_err++;
            $display("FAIL collide_flag: got 1T=%b 2T=%b want 0 1", a_coll, b_coll);
        end
        m_coll_b = 1'b1;
        drive_idle();
        @(negedge clk);
        expect_tx("after_collide", 4'hF, 4'hF);
    endtask

    task automatic test_random_cmd();
        localparam int N = 300;
        logic [3:0] ea, eb;
        bit sp_b, acc, we_n;
        int slot;
        sp_b = 1'b0; ea = 4'hF; eb = 4'hF;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i > 0) begin
                expect_tx("random_lane", ea, eb);
                n_vec++;
                if (a_coll !== m_coll_a || b_coll !== m_coll_b || a_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL random_flags i=%0d: coll %b %b ready %b, want %b %b 1",
                             i, a_coll, b_coll, a_ready, m_coll_a, m_coll_b);
                end
            end
            if (i < N - 2) begin
                acc  = ($urandom_range(0, 3) != 0);
                we_n = ($urandom_range(0, 4) == 0);
                slot = $urandom_range(0, 3);
            end else begin
                acc = 1'b0; we_n = 1'b1; slot = 0;
            end
            cmd_valid = acc; cmd_we_n = we_n; cmd_slot = 2'(slot);
            ea = lane_model(1'b0, acc, we_n, slot, 1'b0);
            eb = lane_model(1'b1, acc, we_n, slot, sp_b);
            if (sp_b && acc && !we_n && slot == 0) m_coll_b = 1'b1;
            sp_b = acc && !we_n && slot == 3;
        end
        drive_idle();
    endtask

    task automatic tap_request(input int target, input int oor_after, input string name);
        int exp_moves, exp_final, nmoves, last_move, loads, waited;
        bit exp_dir, exp_err, done;
        if (target > MAX_TAP) begin
            exp_moves = 0; exp_err = 1'b1; exp_final = m_tap; exp_dir = 1'b0;
        end else begin
            exp_dir   = (target > m_tap);
            exp_moves = exp_dir ? target - m_tap : m_tap - target;
            exp_err   = 1'b0; exp_final = target;
        end
        if (oor_after > 0 && oor_after <= exp_moves) begin
            exp_moves = oor_after; exp_err = 1'b1;
            exp_final = exp_dir ? m_tap + oor_after - 1 : m_tap - (oor_after - 1);
        end
        waited = 0;
        while (a_tap_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (a_tap_ready !== 1'b1 || a_tap_err !== m_err) begin
            n_err++;
            $display("FAIL %s idle: ready %b err %b, want 1 %b", name, a_tap_ready, a_tap_err, m_err);
        end
        tap_req_valid = 1'b1; tap_req_target = 8'(target);
        nmoves = 0; last_move = -100; loads = 0; done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (c == 0) tap_req_valid = 1'b0;
            if (a_move === 1'b1) begin
                nmoves++;
                n_vec++;
                if (a_dir !== exp_dir) begin
                    n_err++;
                    $display("FAIL %s direction move %0d: got %b want %b", name, nmoves, a_dir, exp_dir);
                end
                if (nmoves > 1) begin
                    n_vec++;
                    if (c - last_move != SETTLE_CYC + 1) begin
                        n_err++;
                        $display("FAIL %s move spacing: got %0d want %0d", name, c - last_move, SETTLE_CYC + 1);
                    end
                end
                last_move = c;
                if (nmoves == oor_after) oor = 1'b1;
            end
            if (a_load === 1'b1) loads++;
            n_vec++;
            if (a_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s cmd_ready during tap move: got %b want 1", name, a_ready);
            end
            if (a_tap_done === 1'b1) done = 1'b1;
        end
        oor = 1'b0;
        n_vec++;
        if (!done || nmoves != exp_moves || loads != 0) begin
            n_err++;
            $display("FAIL %s sequence: done %b moves %0d loads %0d, want 1 %0d 0", name, done, nmoves, loads, exp_moves);
        end
        n_vec++;
        if (a_tap_cur !== 8'(exp_final) || a_tap_err !== exp_err || a_tap_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s result: tap %0d err %b ready %b, want %0d %b 1", name, a_tap_cur, a_tap_err, a_tap_ready, exp_final, exp_err);
        end
        @(negedge clk);
        n_vec++;
        if (a_tap_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done width: got %b want 0", name, a_tap_done);
        end
        m_tap = exp_final; m_err = exp_err;
    endtask

    task automatic test_tap_directed();
        tap_request(5, 0, "tap_up_to_5");
        tap_request(200, 0, "tap_range_err");
        tap_request(3, 0, "tap_down_to_3");
        tap_request(3, 0, "tap_same");
    endtask

    task automatic test_tap_random();
        for (int i = 0; i < 6; i++) tap_request($urandom_range(0, 160), 0, "tap_random");
    endtask

    task automatic test_out_of_range();
        tap_request((m_tap < 60) ? m_tap + 10 : m_tap - 10, 2, "tap_oor");
        tap_request(m_tap, 0, "tap_after_oor");
    endtask

    task automatic test_reset_mid_move();
        int nmoves;
        nmoves = 0;
        tap_req_valid = 1'b1;
        tap_req_target = 8'((m_tap <= 87) ? m_tap + 40 : m_tap - 40);
        for (int c = 0; c < 200 && nmoves < 2; c++) begin
            @(negedge clk);
            tap_req_valid = 1'b0;
            if (a_move === 1'b1) nmoves++;
        end
        n_vec++;
        if (nmoves != 2) begin
            n_err++;
            $display("FAIL mid_move_start: moves %0d want 2", nmoves);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("mid_move_reset");
        rst = 1'b0;
        count_init("reinit");
        m_tap = INIT_TAP; m_err = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_t1_directed();
        test_t2_spill_collide();
        test_random_cmd();
        test_tap_directed();
        test_tap_random();
        test_out_of_range();
        test_reset_mid_move();
        tap_request(9, 0, "tap_after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
